// File: rtl/mux_n_1_rr.sv
// N-to-1 valid/ready multiplexer with a registered output stage.
// Channel chosen directly by sel or by round-robin among valid inputs.
module mux_n_1_rr #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_ch
);

  localparam int NSEL = 2 ** SW;
  localparam logic [SW-1:0] LP_LAST = SW'(N - 1);

  logic [NSEL-1:0]  w_valid_ext;
  logic             w_sel_ok;
  logic             w_load_en;
  logic             w_grant_vld;
  logic [SW-1:0]    w_grant_idx;
  logic             w_xfer;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_ch;
  logic [SW-1:0]    r_rr_ptr;

  // Padding to a power of two lets sel index safely; unused channels read as idle.
  always_comb begin
    w_valid_ext         = '0;
    w_valid_ext[N-1:0]  = in_valid;
  end

  assign w_sel_ok  = (32'(sel) < 32'(N));
  assign w_load_en = !r_out_valid || out_ready;

  // Round-robin search starts just after the last granted channel.
  always_comb begin : grant_sel
    int idx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    if (!mode) begin
      if (w_sel_ok && w_valid_ext[sel]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = sel;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(r_rr_ptr) + k) % N;
        if (!w_grant_vld && w_valid_ext[idx[SW-1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = idx[SW-1:0];
        end
      end
    end
  end

  assign w_xfer = w_load_en && w_grant_vld;

  always_comb begin
    in_ready = '0;
    if (rst_n && w_xfer) begin
      in_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= LP_LAST;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[w_grant_idx*WIDTH +: WIDTH];
      r_out_ch    <= w_grant_idx;
      r_rr_ptr    <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
